// File: rtl/mem_ctrl_ifetch_pkg.sv
// mem_ctrl_ifetch_pkg: shared refill constants and FSM state encoding
package mem_ctrl_ifetch_pkg;
  localparam int BLOCK_WIDTH = 1;
  localparam int BLOCK_BITS = 32 << BLOCK_WIDTH;
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
endpackage

// File: rtl/mem_ctrl_ifetch_byte_block_assembler.sv
// byte_block_assembler: inserts refill bytes little-endian into one block register
module byte_block_assembler #(
  parameter int BYTE_CNT = 8,
  parameter int IW = $clog2(BYTE_CNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IW-1:0]         idx,
  input  logic [7:0]            din,
  output logic [8*BYTE_CNT-1:0] block
);
  // byte idx lands at bits [8*idx+7:8*idx]
  always_ff @(posedge clk)
    if (!rst_n) block <= '0;
    else if (we) block[{idx, 3'b000} +: 8] <= din;
endmodule

// File: rtl/mem_ctrl_ifetch.sv
// mem_ctrl_ifetch: responder side of the instruction-cache block refill from byte-wide RAM
module mem_ctrl_ifetch #(
  parameter int BLOCK_WIDTH = mem_ctrl_ifetch_pkg::BLOCK_WIDTH,
  parameter int BLOCK_SIZE = 1 << BLOCK_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    ICMC_en,
  input  logic [ADDR_WIDTH-1:0]   ICMC_addr,
  output logic                    MCIC_en,
  output logic [32*BLOCK_SIZE-1:0] MCIC_block,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  input  logic [7:0]              mem_din,
  output logic                    mem_wr
);
  import mem_ctrl_ifetch_pkg::*;
  localparam int BYTE_CNT = BLOCK_SIZE * 4;
  localparam int IW = $clog2(BYTE_CNT);
  localparam int CW = IW + 1;
  localparam logic [ADDR_WIDTH-1:0] LOW = ADDR_WIDTH'(BYTE_CNT - 1);
  state_t state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0] issue_idx;
  logic [IW-1:0] recv_idx;
  logic [32*BLOCK_SIZE-1:0] asm_block;
  logic cap;
  assign cap = state == READ && Sys_rdy;
  assign mem_wr = 1'b0;
  byte_block_assembler #(.BYTE_CNT(BYTE_CNT)) u_asm (
    .clk(Sys_clk),
    .rst_n(Sys_rst),
    .we(cap),
    .idx(recv_idx),
    .din(mem_din),
    .block(asm_block)
  );
  // refill FSM: address issue runs one byte ahead of capture; a stall re-presents the pending byte
  always_ff @(posedge Sys_clk)
    if (!Sys_rst) begin
      state <= IDLE;
      MCIC_en <= 1'b0;
      MCIC_block <= '0;
      mem_a <= '0;
      base <= '0;
      issue_idx <= '0;
      recv_idx <= '0;
    end else begin
      MCIC_en <= 1'b0;
      case (state)
        IDLE:
          if (ICMC_en && !MCIC_en && Sys_rdy) begin
            base <= ICMC_addr & ~LOW;
            mem_a <= ICMC_addr & ~LOW;
            issue_idx <= CW'(1);
            recv_idx <= '0;
            state <= READ;
          end
        READ:
          if (Sys_rdy) begin
            recv_idx <= recv_idx + IW'(1);
            if (issue_idx < CW'(BYTE_CNT)) begin
              mem_a <= base + ADDR_WIDTH'(issue_idx);
              issue_idx <= issue_idx + CW'(1);
            end
            if (recv_idx == IW'(BYTE_CNT - 1)) state <= DONE;
          end else begin
            mem_a <= base + ADDR_WIDTH'(recv_idx);
            issue_idx <= CW'(recv_idx) + CW'(1);
          end
        DONE:
          if (Sys_rdy) begin
            MCIC_en <= 1'b1;
            MCIC_block <= asm_block;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
